// File: rtl/recv_cpx_chunks_if.sv
// Chunk-stream and packet-handshake bundle for recv_cpx_chunks.
// master = upstream source / downstream consumer side, slave = the receiver.
interface recv_cpx_chunks_if #(
  parameter int PKT_WORDS = 5,
  parameter int ERR_W     = 8
) ();
  logic [63:0]             chunk_in;
  logic                    chunk_empty;
  logic                    chunk_read;
  logic [32*PKT_WORDS-1:0] pkt;
  logic                    pkt_valid;
  logic                    pkt_ack;
  logic                    err_pulse;
  logic [ERR_W-1:0]        err_cnt;

  modport master (
    output chunk_in, chunk_empty, pkt_ack,
    input  chunk_read, pkt, pkt_valid, err_pulse, err_cnt
  );

  modport slave (
    input  chunk_in, chunk_empty, pkt_ack,
    output chunk_read, pkt, pkt_valid, err_pulse, err_cnt
  );
endinterface

// File: rtl/recv_cpx_chunks.sv
// Reassembles {ctrl,data} chunks into PKT_WORDS-word packets with a valid/ack hold stage.
// Define RECV_CPX_ERRCNT_EN to build the saturating protocol-error counter.
module recv_cpx_chunks #(
  parameter int PKT_WORDS = 5,
  parameter int VALID_BIT = 4,
  parameter int SOP_BIT   = 3,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  recv_cpx_chunks_if.slave bus
);

  localparam int PKT_W = 32 * PKT_WORDS;
  localparam int CNT_W = $clog2(PKT_WORDS + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSEMBLE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             err_pulse_q, err_pulse_d;

  logic             pop;
  logic             is_valid;
  logic             is_sop;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic [31:0]      data;

  assign bus.chunk_read = ~bus.chunk_empty & (state_q != HOLD);
  assign pop            = bus.chunk_read;
  assign is_valid       = bus.chunk_in[32+VALID_BIT];
  assign is_sop         = is_valid & bus.chunk_in[32+SOP_BIT];
  assign data           = bus.chunk_in[31:0];

  // Pads (valid bit clear) fall through every branch untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    case (state_q)
      IDLE: begin
        if (pop && is_valid) begin
          if (is_sop) begin
            wr_en   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = ASSEMBLE;
          end else begin
            err_pulse_d = 1'b1;
          end
        end
      end
      ASSEMBLE: begin
        if (pop && is_valid) begin
          wr_en = 1'b1;
          if (is_sop) begin
            err_pulse_d = 1'b1;
            cnt_d       = CNT_W'(1);
          end else begin
            wr_idx = cnt_q;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(PKT_WORDS - 1)) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.pkt_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    pkt_valid_d = (state_d == HOLD);
  end

  // Word k occupies the k-th 32-bit slot counting down from the MSB.
  always_comb begin
    pkt_d = pkt_q;
    for (int k = 0; k < PKT_WORDS; k++) begin
      if (wr_en && (wr_idx == CNT_W'(k))) pkt_d[PKT_W-1-32*k -: 32] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.pkt       = pkt_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.err_pulse = err_pulse_q;

`ifdef RECV_CPX_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Counts alongside the error strobe and sticks at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pulse_d && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_recv_cpx_chunks.sv
// Directed bench for recv_cpx_chunks: expected packets queued at send time, checked on pkt_valid rise.
module tb_recv_cpx_chunks;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   err_seen = 0;
  logic prev_valid = 1'b0;
  logic [159:0] exp_q[$];

  recv_cpx_chunks_if #(.PKT_WORDS(5), .ERR_W(8)) bus ();

  recv_cpx_chunks dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rising pkt_valid consumes one expected packet.
  always @(negedge clk) begin
    if (bus.err_pulse === 1'b1) err_seen++;
    if (bus.pkt_valid === 1'b1 && prev_valid === 1'b0) begin
      if (exp_q.size() == 0) check("sb_unexpected_pkt", bus.pkt, 160'hx);
      else check("sb_pkt", bus.pkt, exp_q.pop_front());
    end
    prev_valid = bus.pkt_valid;
  end

  function automatic logic [63:0] mk(input logic [7:0] ctrl, input logic [31:0] data);
    return {24'h0, ctrl, data};
  endfunction

  // Presents a chunk and returns #1 after the edge that popped it.
  task automatic send(input logic [63:0] c);
    logic seen;
    seen = 1'b0;
    bus.chunk_in    = c;
    bus.chunk_empty = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.chunk_read === 1'b1) begin
        seen = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    check("send_timeout", {159'h0, seen}, 160'h1);
  endtask

  task automatic go_idle();
    bus.chunk_empty = 1'b1;
    bus.chunk_in    = 64'h0;
  endtask

  task automatic send_pkt(input logic [31:0] first);
    logic [159:0] e;
    e = '0;
    for (int k = 0; k < 5; k++) e[159-32*k -: 32] = first + 32'(k);
    exp_q.push_back(e);
    send(mk(8'h18, first));
    for (int k = 1; k < 5; k++) send(mk(8'h10, first + 32'(k)));
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.pkt_valid === 1'b1) seen = 1'b1;
    end
    check("valid_timeout", {159'h0, seen}, 160'h1);
  endtask

  task automatic ack_pkt();
    wait_valid();
    @(posedge clk);
    #1;
    bus.pkt_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_ack = 1'b0;
    check("valid_drop_after_ack", {159'h0, bus.pkt_valid}, 160'h0);
  endtask

  initial begin
    int e0;
    int ack_cyc;
    logic [159:0] ecnt;
    bus.chunk_in    = 64'h0;
    bus.chunk_empty = 1'b1;
    bus.pkt_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt", bus.pkt, 160'h0);
    check("rst_valid", {159'h0, bus.pkt_valid}, 160'h0);
    check("rst_err_pulse", {159'h0, bus.err_pulse}, 160'h0);
    check("rst_err_cnt", {152'h0, bus.err_cnt}, 160'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: basic packet, latency and no pop in HOLD.
    e0 = err_seen;
    exp_q.push_back({32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0005});
    send(mk(8'h18, 32'hAAAA0001));
    for (int k = 2; k <= 4; k++) send(mk(8'h10, 32'hAAAA0000 + 32'(k)));
    check("t1_valid_before_last", {159'h0, bus.pkt_valid}, 160'h0);
    send(mk(8'h10, 32'hAAAA0005));
    check("t1_valid_after_last", {159'h0, bus.pkt_valid}, 160'h1);
    bus.chunk_in = mk(8'h18, 32'h22220000);
    @(negedge clk);
    check("t1_no_read_in_hold", {159'h0, bus.chunk_read}, 160'h0);
    @(posedge clk);
    #1;
    check("t1_still_valid", {159'h0, bus.pkt_valid}, 160'h1);

    // Test 2: ack with the next SOP already waiting; back-to-back period.
    ecnt = '0;
    for (int k = 0; k < 5; k++) ecnt[159-32*k -: 32] = 32'h22220000 + 32'(k);
    exp_q.push_back(ecnt);
    bus.pkt_ack = 1'b1;
    ack_cyc = cyc;
    @(posedge clk);
    #1;
    bus.pkt_ack = 1'b0;
    check("t2_valid_drop", {159'h0, bus.pkt_valid}, 160'h0);
    send(mk(8'h18, 32'h22220000));
    for (int k = 1; k < 5; k++) send(mk(8'h10, 32'h22220000 + 32'(k)));
    check("t2_valid", {159'h0, bus.pkt_valid}, 160'h1);
    check("t2_period", 160'(cyc - ack_cyc), 160'd6);
    go_idle();
    ack_pkt();

    // Ack while idle must be ignored.
    bus.pkt_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_ack = 1'b0;
    check("idle_ack_ignored", {159'h0, bus.pkt_valid}, 160'h0);

    // Test 3: pads interleaved, including one carrying a stray SOP bit.
    exp_q.push_back({32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0005});
    send(mk(8'h00, 32'h0BAD0BAD));
    send(mk(8'h18, 32'hAAAA0001));
    for (int k = 2; k <= 5; k++) begin
      send(mk((k == 3) ? 8'h08 : 8'h00, 32'h0BAD0BAD));
      send(mk(8'h10, 32'hAAAA0000 + 32'(k)));
    end
    go_idle();
    ack_pkt();
    check("t3_no_err", 160'(err_seen - e0), 160'h0);

    // Test 4: stray valid chunk in IDLE.
    e0 = err_seen;
    send(mk(8'h10, 32'hDEAD0000));
    send_pkt(32'h11110000);
    go_idle();
    ack_pkt();
    check("t4_err_pulses", 160'(err_seen - e0), 160'h1);
`ifdef RECV_CPX_ERRCNT_EN
    check("t4_err_cnt", {152'h0, bus.err_cnt}, 160'h1);
`else
    check("t4_err_cnt", {152'h0, bus.err_cnt}, 160'h0);
`endif

    // Test 5: SOP arriving mid-packet restarts assembly.
    e0 = err_seen;
    send(mk(8'h18, 32'hCAFE0000));
    send(mk(8'h10, 32'hCAFE0001));
    send(mk(8'h10, 32'hCAFE0002));
    send_pkt(32'hBEEF0000);
    go_idle();
    ack_pkt();
    check("t5_err_pulses", 160'(err_seen - e0), 160'h1);
`ifdef RECV_CPX_ERRCNT_EN
    check("t5_err_cnt", {152'h0, bus.err_cnt}, 160'h2);
`else
    check("t5_err_cnt", {152'h0, bus.err_cnt}, 160'h0);
`endif

    // Test 6: asynchronous reset in the middle of a packet.
    send(mk(8'h18, 32'h33330000));
    send(mk(8'h10, 32'h33330001));
    send(mk(8'h10, 32'h33330002));
    go_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pkt", bus.pkt, 160'h0);
    check("t6_valid", {159'h0, bus.pkt_valid}, 160'h0);
    check("t6_err_pulse", {159'h0, bus.err_pulse}, 160'h0);
    check("t6_err_cnt", {152'h0, bus.err_cnt}, 160'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pkt(32'h44440000);
    go_idle();
    ack_pkt();

    // Error-counter saturation with a long run of stray valid chunks.
    e0 = err_seen;
    for (int n = 0; n < 300; n++) send(mk(8'h10, 32'hDEAD0000 + 32'(n)));
    go_idle();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sat_err_pulses", 160'(err_seen - e0), 160'd300);
`ifdef RECV_CPX_ERRCNT_EN
    check("sat_err_cnt", {152'h0, bus.err_cnt}, 160'd255);
`else
    check("sat_err_cnt", {152'h0, bus.err_cnt}, 160'h0);
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", 160'(exp_q.size()), 160'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
